// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan capture block.
// Glyph patterns are active-high, bit order g..a (seg[6]=g, seg[0]=a).
package seg7_pkg;

  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_idx_e;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational reverse lookup from a lit-high segment pattern to a hex nibble.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       ok,
  output logic       is_blank
);

  always_comb begin
    nibble   = 4'h0;
    ok       = 1'b0;
    is_blank = 1'b0;
    if (seg == SEG_BLANK) begin
      ok       = 1'b1;
      is_blank = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg == GLYPH[i]) begin
          nibble = 4'(i);
          ok     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers the hex word shown on a multiplexed seven-segment bus, one word per scan frame.
//   state  | meaning
//   S_WAIT | waiting for an addressable sample to be stable long enough to capture
//   S_HOLD | digit captured; ignore until the sample changes
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            seg,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank,
  output logic                  frame_valid,
  output logic                  frame_err
);

  localparam logic [DIGITS-1:0] AN_IDLE   = AN_ACTIVE_LOW  ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [6:0]        SEG_IDLE  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [7:0]        STABLE_M1 = 8'(STABLE_CYCLES - 1);

  logic [DIGITS-1:0]   an_meta, an_sync, an_act, an_prev;
  logic [6:0]          seg_meta, seg_sync, seg_act, seg_prev;
  logic [7:0]          cnt, run;
  logic                same, addressable, capture, frame_done;
  state_e              state, state_nx;
  logic [3:0]          dec_nibble;
  logic                dec_ok, dec_blank;
  logic [DIGITS-1:0]   seen, seen_nx, stage_blank, stage_blank_nx;
  logic [4*DIGITS-1:0] stage_val, stage_val_nx;
  logic                err, err_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_meta  <= AN_IDLE;
      an_sync  <= AN_IDLE;
      seg_meta <= SEG_IDLE;
      seg_sync <= SEG_IDLE;
    end else begin
      an_meta  <= an;
      an_sync  <= an_meta;
      seg_meta <= seg;
      seg_sync <= seg_meta;
    end
  end

  assign an_act      = AN_ACTIVE_LOW  ? ~an_sync  : an_sync;
  assign seg_act     = SEG_ACTIVE_LOW ? ~seg_sync : seg_sync;
  assign same        = (an_act == an_prev) && (seg_act == seg_prev);
  assign addressable = (an_act != '0) && ((an_act & (an_act - 1'b1)) == '0);

  // run = number of repeats of the current sample beyond its first appearance
  always_comb begin
    run = 8'd0;
    if (addressable && same)
      run = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    case (state)
      S_WAIT: if (addressable && run >= STABLE_M1) begin
        capture  = 1'b1;
        state_nx = S_HOLD;
      end
      S_HOLD: if (!same) state_nx = S_WAIT;
      default: state_nx = S_WAIT;
    endcase
  end

  seg7_glyph_decode u_decode (
    .seg      (seg_act),
    .nibble   (dec_nibble),
    .ok       (dec_ok),
    .is_blank (dec_blank)
  );

  always_comb begin
    stage_val_nx   = stage_val;
    stage_blank_nx = stage_blank;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_act[i]) begin
        stage_val_nx[4*i +: 4] = dec_nibble;
        stage_blank_nx[i]      = dec_blank;
      end
    end
    seen_nx    = seen | an_act;
    err_nx     = err | ~dec_ok;
    frame_done = capture && (&seen_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_WAIT;
      an_prev     <= '0;
      seg_prev    <= '0;
      cnt         <= 8'd0;
      seen        <= '0;
      err         <= 1'b0;
      stage_val   <= '0;
      stage_blank <= '0;
      value       <= '0;
      blank       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nx;
      an_prev     <= an_act;
      seg_prev    <= seg_act;
      cnt         <= run;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (capture) begin
        stage_val   <= stage_val_nx;
        stage_blank <= stage_blank_nx;
        if (frame_done) begin
          seen <= '0;
          err  <= 1'b0;
          if (!err_nx) begin
            value       <= stage_val_nx;
            blank       <= stage_blank_nx;
            frame_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          seen <= seen_nx;
          err  <= err_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Drives scan patterns onto the display bus and scoreboards each frame pulse against queued expectations.
module tb_seg7_scan_capture;

  typedef struct packed {
    logic        err;
    logic [15:0] value;
    logic [3:0]  blank;
  } frame_t;

  localparam logic [6:0] G0 = 7'h3F, G1 = 7'h06, G2 = 7'h5B, G3 = 7'h4F;
  localparam logic [6:0] G4 = 7'h66, G5 = 7'h6D, G6 = 7'h7D, G7 = 7'h07;
  localparam logic [6:0] G8 = 7'h7F, G9 = 7'h6F, GA = 7'h77, GB = 7'h7C;
  localparam logic [6:0] GC = 7'h39, GD = 7'h5E, GE = 7'h79, GF = 7'h71;
  localparam logic [6:0] GDARK = 7'h00, GBAD = 7'h40;

  logic        clk, rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        frame_valid, frame_err;

  int n_checks = 0;
  int n_errors = 0;
  frame_t exp_q[$];

  seg7_scan_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .seg         (seg),
    .value       (value),
    .blank       (blank),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // pins are active-low for both anodes and segments
  task automatic drive(input int d, input logic [6:0] g, input int dwell);
    logic [3:0] sel;
    sel = 4'b0001 << d;
    an  = ~sel;
    seg = ~g;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic glitch(input logic [3:0] act, input logic [6:0] g, input int dwell);
    an  = ~act;
    seg = ~g;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic push(input logic e, input logic [15:0] v, input logic [3:0] b);
    frame_t f;
    f.err   = e;
    f.value = v;
    f.blank = b;
    exp_q.push_back(f);
  endtask

  task automatic drain(input string tag);
    glitch(4'b0000, GDARK, 14);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (frame_valid || frame_err) begin
      check("pulse_exclusive", {31'd0, frame_valid & frame_err}, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, frame_valid, frame_err}, 0);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        check("frame_err",   {31'd0, frame_err},   {31'd0, e.err});
        check("frame_valid", {31'd0, frame_valid}, {31'd0, ~e.err});
        check("value",       {16'd0, value},       {16'd0, e.value});
        check("blank",       {28'd0, blank},       {28'd0, e.blank});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    repeat (3) @(negedge clk);
    check("reset_value",       {16'd0, value}, 0);
    check("reset_blank",       {28'd0, blank}, 0);
    check("reset_frame_valid", {31'd0, frame_valid}, 0);
    check("reset_frame_err",   {31'd0, frame_err}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // ordered scan, two frames
    for (int s = 0; s < 2; s++) begin
      push(1'b0, 16'h4321, 4'b0000);
      drive(0, G1, 8); drive(1, G2, 8); drive(2, G3, 8); drive(3, G4, 8);
    end
    drain("ordered_pending");

    // reverse order with dark digit 0
    for (int s = 0; s < 2; s++) begin
      push(1'b0, 16'hEDC0, 4'b0001);
      drive(3, GE, 8); drive(2, GD, 8); drive(1, GC, 8); drive(0, GDARK, 8);
    end
    drain("reverse_pending");

    // undecodable glyph: error frame keeps previous outputs, next frame is clean
    push(1'b1, 16'hEDC0, 4'b0001);
    drive(0, G9, 8); drive(1, G8, 8); drive(2, GBAD, 8); drive(3, GA, 8);
    push(1'b0, 16'hFBA5, 4'b0000);
    drive(0, G5, 8); drive(1, GA, 8); drive(2, GB, 8); drive(3, GF, 8);
    drain("invalid_pending");

    // glitch anode patterns between digits must not be captured
    push(1'b0, 16'hC702, 4'b0000);
    drive(0, G2, 8);
    glitch(4'b0000, G8, 6);
    drive(1, G0, 8);
    glitch(4'b0011, G8, 6);
    drive(2, G7, 8);
    glitch(4'b1100, G6, 6);
    drive(3, GC, 8);
    drain("glitch_pending");

    // reset after two digits: partial frame discarded
    drive(0, G3, 8); drive(1, G9, 8);
    rst_n = 1'b0;
    #1;
    check("midreset_value",       {16'd0, value}, 0);
    check("midreset_blank",       {28'd0, blank}, 0);
    check("midreset_frame_valid", {31'd0, frame_valid}, 0);
    check("midreset_frame_err",   {31'd0, frame_err}, 0);
    glitch(4'b0000, GDARK, 3);
    rst_n = 1'b1;
    glitch(4'b0000, GDARK, 3);
    push(1'b0, 16'h6587, 4'b0000);
    drive(2, G5, 8); drive(3, G6, 8); drive(0, G7, 8); drive(1, G8, 8);
    drain("reset_pending");

    // short dwell on digit 1: frame only completes on the next scan's digit 1
    push(1'b0, 16'h4321, 4'b0000);
    drive(0, G1, 8); drive(1, G2, 3); drive(2, G3, 8); drive(3, G4, 8);
    drive(0, G1, 8); drive(1, G2, 8);
    drive(2, G3, 8); drive(3, G4, 8);
    drain("short_dwell_pending");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Receive-side counterpart of the hex-to-seven-segment encoder. It observes a time-multiplexed seven-segment display bus (digit anodes plus shared segment lines) and recovers the displayed hex value. For each digit it waits until the anode and segment pattern are stable, then decodes the glyph back to a nibble. It emits one complete multi-digit word per scan frame. It is used in self-checking benches and in board loopback tests of the display path.

## Interface
- `DIGITS`, default 4: number of multiplexed digits (anode lines).
- `STABLE_CYCLES`, default 4: consecutive identical samples required before capture; legal range 1 to 255.
- `SEG_ACTIVE_LOW`, default 1: when 1, segment lines are lit-low.
- `AN_ACTIVE_LOW`, default 1: when 1, anode lines are selected-low.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `an` in `DIGITS`: digit select lines; asynchronous to `clk`.
- `seg` in 7: segment lines; `seg[0]`=a through `seg[6]`=g; asynchronous to `clk`.
- `value` out `4*DIGITS`: last complete frame; digit i occupies bits `[4i+3:4i]`.
- `blank` out `DIGITS`: bit i is set if digit i was dark in the last complete frame.
- `frame_valid` out 1: one-cycle pulse; `value`/`blank` updated this cycle.
- `frame_err` out 1: one-cycle pulse; the frame held an undecodable glyph and `value`/`blank` were not updated.

## Operation
- **Input synchronisation**
  - `an` and `seg` pass through a 2-flop synchroniser.
  - They are then normalised to active-high using the polarity parameters.
  - The normalised pair is the "sample".
- **Select check**
  - A sample is addressable only if `an` is exactly one-hot.
  - A sample with zero or multiple anodes active is ignored and clears the stability counter.
- **FSM: WAIT**
  - Entered from reset.
  - Tracks a stability counter `cnt` (8 bits). `cnt` is cleared whenever the sample differs from the previous sample, or the sample is not addressable.
  - Otherwise `cnt` increments.
  - When an addressable sample has been held `STABLE_CYCLES` consecutive cycles: capture, then go to HOLD.
- **FSM: HOLD**
  - No further captures.
  - On any sample change: clear `cnt` and return to WAIT.
  - This guarantees at most one capture per digit dwell.
- **Capture**
  - Decode `seg` (normalised, bit order g..a) against the glyph table:
    - 0=0111111, 1=0000110, 2=1011011, 3=1001111
    - 4=1100110, 5=1101101, 6=1111101, 7=0000111
    - 8=1111111, 9=1101111, A=1110111, b=1111100
    - C=0111001, d=1011110, E=1111001, F=1110001
  - 0000000 is blank: nibble 0, staged blank bit set.
  - Any other pattern sets the staged error flag.
  - Write the nibble into staging slot i (i = index of the active anode) and set `seen[i]`.
  - A re-capture of the same digit before the frame completes overwrites the slot; latest wins.
- **Frame completion**
  - Triggered on the capture that makes `seen` all ones.
  - If the error flag is clear: copy staging to `value`/`blank` and pulse `frame_valid`.
  - If the error flag is set: pulse `frame_err` and leave `value`/`blank` unchanged.
  - In both cases clear `seen` and the error flag.
- `frame_valid` and `frame_err` are never high together.

## Timing
- **Reset values:**
  - `value`=0, `blank`=0, `frame_valid`=0, `frame_err`=0.
  - `seen`=0, error flag=0, `cnt`=0.
  - Synchroniser flops = deasserted levels; FSM=WAIT.
- **Latency:**
  - The pin change reaches the sample after 2 cycles.
  - The capture edge occurs `STABLE_CYCLES` cycles after the first stable sample.
  - On the final capture edge, `frame_valid` (or `frame_err`) and `value` register together and are visible in the following cycle.
- **Minimum dwell:** a digit is lost if its stable dwell is shorter than `STABLE_CYCLES` sampled cycles. There is no error for this; the frame simply takes longer.
- **Reset mid-frame:** partial staging is discarded and no pulse is emitted.

## Structure
- Package `seg7_pkg` holds:
  - the 16 glyph constants;
  - `SEG_BLANK`;
  - a segment-index enum (`SEG_A`..`SEG_G`);
  - the WAIT/HOLD state typedef.
- One combinational sub-module, `seg7_glyph_decode`:
  - input: `seg[6:0]`;
  - outputs: `nibble[3:0]`, `ok`, `is_blank`.
- The top level holds the synchroniser, counter, FSM, staging and output registers.

## Test plan
- **Ordered scan.** Drive the default parameters with a clean scan of digits 0..3 showing 1,2,3,4 glyphs, 8 cycles per digit. Required: `frame_valid` pulses once per scan, `value`=16'h4321, `blank`=0.
- **Reverse order with dark digit.** Scan digits 3..0 with E,d,C and digit 0 dark. Required: `value`=16'hEDC0, `blank`=4'b0001.
- **Invalid glyph.** Put pattern 1000000 on digit 2 for one frame. Required: `frame_err` pulse, `value` holds the previous frame. The next clean frame gives `frame_valid` with new data.
- **Short dwell.** Digit 1 dwells only 3 cycles with `STABLE_CYCLES`=4. Required: no pulse that scan; the frame completes on the next scan with full dwell.
- **Bad anode patterns.** Apply glitch anode patterns (4'b0000 or 2 hot) between digits. Required: no capture on them; captured values are unaffected.
- **Reset mid-frame.** Assert `rst_n` low after 2 digits are captured. Required: all outputs are 0 immediately, and there is no `frame_valid` until a full new scan is captured.
